// File: rtl/frodo_ctrl_pkg.sv
// rtl/frodo_ctrl_pkg.sv - opcodes, config encodings, program bases and states for the Frodo control path
package frodo_ctrl_pkg;

  localparam int PC_W = 8;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_MATMUL = 3'b001,
    OP_SAMPLE = 3'b010,
    OP_PACK   = 3'b011,
    OP_HASH   = 3'b100,
    OP_ADD    = 3'b101,
    OP_MOVE   = 3'b110,
    OP_HALT   = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    LVL_640     = 2'b00,
    LVL_976     = 2'b01,
    LVL_1344    = 2'b10,
    LVL_INVALID = 2'b11
  } level_e;

  typedef enum logic [1:0] {
    MODE_KEYGEN  = 2'b00,
    MODE_ENCAPS  = 2'b01,
    MODE_DECAPS  = 2'b10,
    MODE_INVALID = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BAD_CFG = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_PC_OVF  = 2'b11
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH,
    ST_ERROR
  } sched_state_e;

  function automatic logic cfg_valid(input logic [1:0] level, input logic [1:0] mode);
    return (level != LVL_INVALID) && (mode != MODE_INVALID);
  endfunction

  // Microprogram entry points, indexed {level, mode}; invalid combinations never reach the ROM.
  function automatic logic [PC_W-1:0] prog_base(input logic [3:0] sel);
    logic [PC_W-1:0] base;
    case (sel)
      4'b0000: base = 8'h00;
      4'b0001: base = 8'h10;
      4'b0010: base = 8'h20;
      4'b0100: base = 8'h30;
      4'b0101: base = 8'h40;
      4'b0110: base = 8'h50;
      4'b1000: base = 8'h60;
      4'b1001: base = 8'h70;
      4'b1010: base = 8'hFE;
      default: base = 8'h00;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/issue_timer.sv
// rtl/issue_timer.sv - clearable cycle counter that flags when a programmable limit is reached
module issue_timer #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] count_q;

  // Counting stops at the limit so expired_o stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/inst_scheduler.sv
// rtl/inst_scheduler.sv - fetches microprogram words from ROM and issues them one at a time to the datapath
module inst_scheduler
  import frodo_ctrl_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 28,
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            level,
  input  logic [1:0]            mode_ctrl,
  output logic                  rom_en,
  output logic [PC_WIDTH-1:0]   rom_addr,
  input  logic [INST_WIDTH-1:0] rom_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  exec_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code,
  output logic [PC_WIDTH-1:0]   inst_count
);

  sched_state_e          state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   inst_count_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  rom_en_q;
  logic                  inst_valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [1:0]            error_code_q;

  logic [2:0]            opcode_d;
  logic [PC_WIDTH-1:0]   base_d;
  logic                  timer_clear_d;
  logic                  timer_en_d;
  logic                  timer_expired;

  assign opcode_d      = rom_data[INST_WIDTH-1 -: 3];
  assign base_d        = PC_WIDTH'(prog_base({level, mode_ctrl}));
  // The ISSUE cycle counts, so expiry lands exactly TIMEOUT cycles after the strobe.
  assign timer_clear_d = (state_q == ST_DECODE);
  assign timer_en_d    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  issue_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_issue_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear_d),
    .en_i     (timer_en_d),
    .expired_o(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      inst_q       <= '0;
      inst_count_q <= '0;
      rom_en_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= ERR_NONE;
    end else begin
      rom_en_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              if (!cfg_valid(level, mode_ctrl)) begin
                state_q      <= ST_ERROR;
                error_q      <= 1'b1;
                error_code_q <= ERR_BAD_CFG;
              end else begin
                state_q      <= ST_FETCH;
                pc_q         <= base_d;
                inst_count_q <= '0;
                error_q      <= 1'b0;
                error_code_q <= ERR_NONE;
                busy_q       <= 1'b1;
                rom_en_q     <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            state_q <= ST_DECODE;
          end
          ST_DECODE: begin
            if (opcode_d == OP_HALT) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q      <= ST_ISSUE;
              inst_q       <= rom_data;
              inst_valid_q <= 1'b1;
              inst_count_q <= (&inst_count_q) ? inst_count_q : inst_count_q + 1'b1;
            end
          end
          ST_ISSUE: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            // A completion in the final timer cycle still counts as a normal completion.
            if (exec_done) begin
              if (&pc_q) begin
                state_q      <= ST_ERROR;
                error_q      <= 1'b1;
                error_code_q <= ERR_PC_OVF;
                busy_q       <= 1'b0;
              end else begin
                state_q  <= ST_FETCH;
                pc_q     <= pc_q + 1'b1;
                rom_en_q <= 1'b1;
              end
            end else if (timer_expired) begin
              state_q      <= ST_ERROR;
              error_q      <= 1'b1;
              error_code_q <= ERR_TIMEOUT;
              busy_q       <= 1'b0;
            end
          end
          ST_FINISH: begin
            state_q <= ST_IDLE;
          end
          ST_ERROR: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign rom_en     = rom_en_q;
  assign rom_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q && !abort;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign error_code = error_code_q;
  assign inst_count = inst_count_q;

endmodule

// File: doc/inst_scheduler.md
Name: inst_scheduler

Overview:
- Sequences the Frodo datapath: on `start`, selects a microprogram from `level`/`mode_ctrl` and fetches 28-bit instructions from a synchronous program ROM.
- Issues instructions one at a time as single-cycle `inst_valid` pulses and waits for the datapath's `exec_done` before fetching the next one.
- Sits between the top-level control pins and the datapath instruction port, replacing bench-driven instruction injection.

Parameters:
- INST_WIDTH, 28, instruction width; opcode is bits [INST_WIDTH-1:INST_WIDTH-3].
- PC_WIDTH, 8, program ROM address width.
- TIMEOUT, 100000, maximum cycles from issue to `exec_done` before error.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin program; sampled only in IDLE.
- abort  in  1  cancel running program.
- level  in  2  00=640, 01=976, 10=1344, 11=invalid.
- mode_ctrl  in  2  00=keygen, 01=encaps, 10=decaps, 11=invalid.
- rom_en  out  1  ROM read enable.
- rom_addr  out  PC_WIDTH  ROM address.
- rom_data  in  INST_WIDTH  ROM data, valid 1 cycle after `rom_en`.
- inst  out  INST_WIDTH  instruction to datapath.
- inst_valid  out  1  one-cycle issue strobe.
- exec_done  in  1  datapath completion pulse.
- busy  out  1  program running.
- done  out  1  one-cycle pulse on HALT.
- error  out  1  sticky until next accepted start.
- error_code  out  2  01=bad config, 10=timeout, 11=PC overflow.
- inst_count  out  PC_WIDTH  instructions issued in current/last program.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; pc=0; timeout counter=0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, FINISH, ERROR.
- IDLE, start=0:
  - Stay in IDLE.
- IDLE, start=1 with level=11 or mode_ctrl=11:
  - Go to ERROR with error_code=01.
- IDLE, start=1 with valid config:
  - pc <= PROG_BASE[{level,mode_ctrl}]; inst_count<=0; error, error_code cleared; busy=1 from the next cycle; go to FETCH.
- FETCH:
  - rom_en=1, rom_addr=pc for exactly one cycle; go to DECODE.
- DECODE:
  - rom_data is valid this cycle.
  - Opcode == OP_HALT (3'b111): go to FINISH.
  - Otherwise: register `inst`<=rom_data, go to ISSUE.
- ISSUE:
  - inst_valid=1 for one cycle; inst_count++ (saturating); timer cleared; go to WAIT.
  - `inst` holds its value until the next issue.
- WAIT:
  - exec_done=1: pc++, go to FETCH. If pc is already all-ones, go to ERROR with error_code=11 instead.
  - exec_done sampled in the ISSUE cycle is ignored; the datapath guarantees at least 1 cycle of latency.
  - Timer increments each WAIT cycle. When it reaches TIMEOUT-1 with no exec_done, go to ERROR with error_code=10.
  - exec_done in that same final cycle wins: it is treated as a normal completion.
- Issue-to-issue minimum:
  - exec_done in the first WAIT cycle gives FETCH, DECODE, ISSUE → 4 cycles between inst_valid pulses.
- FINISH:
  - done=1 for one cycle, busy<=0, go to IDLE.
  - First instruction HALT (empty program): done still pulses, inst_count=0.
- ERROR:
  - error=1 (sticky), busy=0, go to IDLE in the same cycle.
  - error stays high until the next valid start is accepted.
- abort:
  - In any non-IDLE state: next state IDLE, busy<=0, no done, no error, inst_valid forced 0 that cycle.
  - abort and start together in IDLE: abort wins, start ignored.
- start while busy:
  - Ignored, no queueing.
- rst mid-program:
  - Returns everything to reset values on the next edge; ROM read in flight is discarded.
- PC overflow check:
  - Applies only on increment, never on the base load.

Decomposition:
- Shared package `frodo_ctrl_pkg`:
  - OP_HALT and the other opcode constants.
  - Level and mode encodings.
  - PROG_BASE table (16 entries of PC_WIDTH, indexed {level,mode_ctrl}).
  - Error code constants.
  - State enum.
- Sub-module `issue_timer`:
  - Clearable counter with compare against TIMEOUT, outputs `expired`.
  - Reused later for the DMA channel watchdog.

Test Plan:
- Encaps at level 976: program at PROG_BASE[0101] = 3 instructions + HALT, datapath returns exec_done 2 cycles after each issue -> 3 inst_valid pulses with matching inst words, done pulse once, inst_count=3, busy drops the same cycle done pulses.
- start with level=11, mode=00 -> no rom_en ever asserted; error=1, error_code=01 the next cycle; a subsequent valid start clears error.
- Datapath never returns exec_done, TIMEOUT overridden to 20 -> error_code=10 exactly 20 cycles after the inst_valid pulse; no done.
- abort asserted during WAIT of the 2nd instruction -> back to IDLE next cycle, busy=0, done=0, error=0; a new start runs the full program from its base.
- Program with HALT as first word -> done pulses 3 cycles after start, inst_count=0, no inst_valid.
- Program base at 8'hFE with no HALT before address 8'hFF, exec_done returned -> error_code=11 after the 2nd exec_done; start pulsed while busy has no effect.
